// File: rtl/result_display.sv
// ============================================================================
//  Module      : result_display
//  Description : Captures a 32-bit result word on a load strobe and shows it
//                on an 8-digit common-anode multiplexed seven-segment display,
//                in hex or unsigned decimal (sequential shift-add-3 BCD).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_display #(
    parameter int DIGIT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data,
    input  logic        dec_mode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        busy
);

    localparam int                 c_PRE_W   = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(DIGIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         shift_q, shift_d;
    logic [39:0]         bcd_q,   bcd_d;
    logic [4:0]          iter_q,  iter_d;
    logic [31:0]         digits_q, digits_d;
    logic [7:0]          blank_q,  blank_d;
    logic                ovf_q,    ovf_d;
    logic                busy_q;
    logic [c_PRE_W-1:0]  pre_q;
    logic [2:0]          idx_q;
    logic [6:0]          seg_q;
    logic                dp_q;
    logic [7:0]          an_q;

    logic [39:0]         w_bcd_adj;
    logic [7:0]          w_blank;
    logic [3:0]          w_code;

    // Seven-segment pattern, active-low, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_pattern(input logic [3:0] code);
        logic [6:0] p;
        case (code)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        w_bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking: a digit goes dark when it and every digit above it
    // (including the two overflow digits) are zero; digit 0 always stays lit.
    always_comb begin
        logic v_seen;
        w_blank = 8'h00;
        v_seen  = |bcd_q[39:32];
        for (int i = 7; i >= 1; i--) begin
            if (bcd_q[i*4 +: 4] != 4'd0) begin
                v_seen = 1'b1;
            end
            w_blank[i] = ~v_seen;
        end
    end

    // Next-state logic: load capture, conversion iterations and commit.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        iter_d   = iter_q;
        digits_d = digits_q;
        blank_d  = blank_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    if (dec_mode) begin
                        shift_d = data;
                        bcd_d   = 40'd0;
                        iter_d  = 5'd0;
                        state_d = S_CONV;
                    end else begin
                        digits_d = data;
                        blank_d  = 8'h00;
                        ovf_d    = 1'b0;
                    end
                end
            end
            S_CONV: begin
                {bcd_d, shift_d} = {w_bcd_adj, shift_q} << 1;
                iter_d           = iter_q + 5'd1;
                if (iter_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                digits_d = bcd_q[31:0];
                ovf_d    = |bcd_q[39:32];
                blank_d  = w_blank;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM, converter and display-buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            shift_q  <= 32'd0;
            bcd_q    <= 40'd0;
            iter_q   <= 5'd0;
            digits_q <= 32'd0;
            blank_q  <= 8'h00;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            iter_q   <= iter_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
            ovf_q    <= ovf_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

    // Scan prescaler and digit index; runs regardless of the converter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
            idx_q <= 3'd0;
        end else if (pre_q == c_PRE_MAX) begin
            pre_q <= '0;
            idx_q <= idx_q + 3'd1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    assign w_code = digits_q[{idx_q, 2'b00} +: 4];

    // Registered anode, segment and decimal-point drive for the current digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= 8'hFE;
            seg_q <= 7'h40;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= ~(8'd1 << idx_q);
            seg_q <= blank_q[idx_q] ? 7'h7F : seg_pattern(w_code);
            dp_q  <= ~ovf_q;
        end
    end

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule

`default_nettype wire
